// File: rtl/sprite_compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared types and constants for the sprite compositor.
//             - RGB332 pixel type
//             - Default transparent colour key
//             - Screen coordinate width
//             - Sprite position struct
//  Revision : 1.0  initial release
// ============================================================================
package sprite_pkg;

  localparam int COORD_W = 10;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t KEY_DEFAULT = 8'hE3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_pos_t;

endpackage
`default_nettype wire

// File: rtl/sprite_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor_if
//  Purpose  : Pixel-stream, shadow-register and ROM bus between the VGA
//             generator / ROMs (master) and the compositor (slave).
//  Signals  : x_ptr, y_ptr, valid, frame_tick  pixel stream and frame strobe
//             spr_x, spr_y, spr_en            packed sprite positions / enables
//             addr_bg, data_bg                background ROM port
//             addr_spr, data_spr              packed sprite ROM ports
//             RGB, valid_out, collide         composited output and flags
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_compositor_if
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int SPR_AW    = 9,
  parameter int BG_LOG2   = 8
) ();

  logic [COORD_W-1:0]           x_ptr;
  logic [COORD_W-1:0]           y_ptr;
  logic                         valid;
  logic                         frame_tick;
  logic [COORD_W*N_SPRITES-1:0] spr_x;
  logic [COORD_W*N_SPRITES-1:0] spr_y;
  logic [N_SPRITES-1:0]         spr_en;
  logic [2*BG_LOG2-1:0]         addr_bg;
  rgb332_t                      data_bg;
  logic [SPR_AW*N_SPRITES-1:0]  addr_spr;
  logic [8*N_SPRITES-1:0]       data_spr;
  rgb332_t                      RGB;
  logic                         valid_out;
  logic [N_SPRITES-1:0]         collide;

  modport master (
    output x_ptr, y_ptr, valid, frame_tick, spr_x, spr_y, spr_en,
    output data_bg, data_spr,
    input  addr_bg, addr_spr, RGB, valid_out, collide
  );

  modport slave (
    input  x_ptr, y_ptr, valid, frame_tick, spr_x, spr_y, spr_en,
    input  data_bg, data_spr,
    output addr_bg, addr_spr, RGB, valid_out, collide
  );

endinterface
`default_nettype wire

// File: rtl/sprite_compositor_hit.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_hit
//  Purpose  : Combinational bounds test and ROM address for one sprite.
//  Ports    : x_i, y_i   current pixel
//             pos_i      sprite top-left corner (shadow copy)
//             en_i       sprite enable (shadow copy)
//             hit_o      pixel lies inside the sprite
//             addr_o     sprite ROM address, 0 on a miss
//  Revision : 1.0  initial release
// ============================================================================
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 32,
  parameter int SPR_AW = 9
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  sprite_pos_t        pos_i,
  input  logic               en_i,
  output logic               hit_o,
  output logic [SPR_AW-1:0]  addr_o
);

  localparam int LOG2W = $clog2(SPR_W);
  localparam logic [COORD_W:0] W_EXT = SPR_W[COORD_W:0];
  localparam logic [COORD_W:0] H_EXT = SPR_H[COORD_W:0];

  // One extra bit so that sx+SPR_W past column 1023 clips instead of wrapping.
  logic [COORD_W:0]   x_ext, y_ext, sx_ext, sy_ext;
  logic [COORD_W-1:0] dx, dy;
  logic               in_x, in_y;

  assign x_ext  = {1'b0, x_i};
  assign y_ext  = {1'b0, y_i};
  assign sx_ext = {1'b0, pos_i.x};
  assign sy_ext = {1'b0, pos_i.y};

  assign in_x  = (x_ext >= sx_ext) && (x_ext < sx_ext + W_EXT);
  assign in_y  = (y_ext >= sy_ext) && (y_ext < sy_ext + H_EXT);
  assign hit_o = en_i && in_x && in_y;

  assign dx = x_i - pos_i.x;
  assign dy = y_i - pos_i.y;

  // SPR_W is a power of two, so row*SPR_W is a shift.
  assign addr_o = hit_o ? ((SPR_AW'(dy) << LOG2W) + SPR_AW'(dx)) : '0;

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Composites a tiled background and N_SPRITES sprites onto the
//             VGA pixel stream with a 3-cycle fixed latency, and reports
//             per-frame collisions between sprite 0 and every other sprite.
//  Ports    : clk   pixel clock
//             rst   asynchronous active-high reset
//             bus   sprite_compositor_if.slave (pixel stream, ROMs, outputs)
//  Revision : 1.0  initial release
// ============================================================================
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int      N_SPRITES = 4,
  parameter int      SPR_W     = 16,
  parameter int      SPR_H     = 32,
  parameter int      SPR_AW    = 9,
  parameter int      BG_LOG2   = 8,
  parameter rgb332_t KEY       = KEY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  sprite_compositor_if.slave bus
);

  // Shadow copies of the sprite registers, refreshed only on frame_tick.
  sprite_pos_t                 pos_q [N_SPRITES];
  logic [N_SPRITES-1:0]        en_q;

  logic [N_SPRITES-1:0]        hit_d;
  logic [SPR_AW*N_SPRITES-1:0] addr_spr_d;

  logic [2*BG_LOG2-1:0]        addr_bg_q;
  logic [SPR_AW*N_SPRITES-1:0] addr_spr_q;
  logic [N_SPRITES-1:0]        hit0_q, hit1_q;
  logic                        valid0_q, valid1_q;
  rgb332_t                     rgb_q, rgb_d;
  logic                        valid_out_q;
  logic [N_SPRITES-1:0]        opaque;
  logic [N_SPRITES-1:0]        acc_q, acc_d;
  logic [N_SPRITES-1:0]        collide_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < N_SPRITES; i++) pos_q[i] <= '0;
    end else if (bus.frame_tick) begin
      en_q <= bus.spr_en;
      for (int i = 0; i < N_SPRITES; i++) begin
        pos_q[i].x <= bus.spr_x[COORD_W*i +: COORD_W];
        pos_q[i].y <= bus.spr_y[COORD_W*i +: COORD_W];
      end
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
    sprite_hit #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .SPR_AW (SPR_AW)
    ) u_hit (
      .x_i    (bus.x_ptr),
      .y_i    (bus.y_ptr),
      .pos_i  (pos_q[g]),
      .en_i   (en_q[g]),
      .hit_o  (hit_d[g]),
      .addr_o (addr_spr_d[SPR_AW*g +: SPR_AW])
    );
  end

  // Stage 2: scan from the highest index down so the lowest opaque index
  // is the last writer and therefore wins.
  always_comb begin
    opaque = '0;
    rgb_d  = bus.data_bg;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit1_q[i] && (bus.data_spr[8*i +: 8] != KEY)) begin
        opaque[i] = 1'b1;
        rgb_d     = bus.data_spr[8*i +: 8];
      end
    end
    if (!valid1_q) rgb_d = '0;

    acc_d = acc_q;
    for (int i = 1; i < N_SPRITES; i++) begin
      if (valid1_q && opaque[0] && opaque[i]) acc_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_bg_q   <= '0;
      addr_spr_q  <= '0;
      hit0_q      <= '0;
      valid0_q    <= 1'b0;
      hit1_q      <= '0;
      valid1_q    <= 1'b0;
      rgb_q       <= '0;
      valid_out_q <= 1'b0;
      acc_q       <= '0;
      collide_q   <= '0;
    end else begin
      addr_bg_q   <= {bus.y_ptr[BG_LOG2-1:0], bus.x_ptr[BG_LOG2-1:0]};
      addr_spr_q  <= addr_spr_d;
      hit0_q      <= hit_d;
      valid0_q    <= bus.valid;
      hit1_q      <= hit0_q;
      valid1_q    <= valid0_q;
      rgb_q       <= rgb_d;
      valid_out_q <= valid1_q;
      // A collision on the tick cycle itself still lands in this frame's report.
      if (bus.frame_tick) begin
        collide_q <= acc_d;
        acc_q     <= '0;
      end else begin
        acc_q     <= acc_d;
      end
    end
  end

  assign bus.addr_bg   = addr_bg_q;
  assign bus.addr_spr  = addr_spr_q;
  assign bus.RGB       = rgb_q;
  assign bus.valid_out = valid_out_q;
  assign bus.collide   = collide_q;

endmodule
`default_nettype wire
